inert_seq: RTL and testbench
============================

# inert_seq

Sequencer between the Knights-Tour command path and the SPI monarch that talks to the iNEMO inertial sensor. After power-up it waits out the sensor's power-on delay, then writes the two configuration registers that start the sensor's measurement cycle. It then services every sensor interrupt by reading the rate registers, and presents assembled 16-bit samples with a one-cycle valid strobe.

## Interface
Parameters:
- INIT_WAIT_BITS, 16, width of power-on wait counter; wait is 2^INIT_WAIT_BITS clk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- INT  in  1  sensor interrupt; asynchronous to clk.
- done  in  1  SPI monarch transaction complete; one-cycle pulse.
- rd_data  in  16  SPI monarch received word; response byte is in [7:0].
- wrt  out  1  one-cycle pulse that starts an SPI transaction.
- cmd  out  16  SPI command word; held stable from wrt until done.
- cfg_done  out  1  high once both configuration writes have completed.
- vld  out  1  one-cycle pulse; a new sample set is on the data outputs.
- ptch_rt  out  16  pitch rate sample.
- roll_rt  out  16  roll rate sample.
- yaw_rt  out  16  yaw rate sample.
- ax  out  16  X acceleration sample (see Configuration).
- ay  out  16  Y acceleration sample (see Configuration).

## Operation
- INT passes through a two-flop synchronizer (INT_ff1 then INT_ff2). Only INT_ff2 is used.
- State machine:
  - PWR_WAIT: the wait counter runs from 0. When it is all-ones, go to CFG_WR1.
  - CFG_WR1: pulse wrt with cmd = 16'h0D02. Hold until done, then go to CFG_WR2.
  - CFG_WR2: pulse wrt with cmd = 16'h1160. Hold until done, then set cfg_done and go to WAIT_INT.
  - WAIT_INT: when INT_ff2 = 1, go to READ.
  - READ: issue the read list in order, one transaction at a time.
  - After the last done: go to UPDATE, load all output registers, pulse vld, then return to WAIT_INT.
- Read list, cmd = {1'b1, addr[6:0], 8'h00}:
  - A200, A300: pitch low, pitch high. The A200 read clears INT in the sensor.
  - A400, A500: roll low, roll high.
  - A600, A700: yaw low, yaw high.
- Read-list sequencing:
  - A 4-bit read index selects the current cmd.
  - On each done in READ, rd_data[7:0] is captured into the staging byte for that index.
  - Captured values reach the outputs only in UPDATE, so the outputs never show a mix of old and new halves.
- Handshake:
  - wrt is registered and high for exactly one cycle per transaction.
  - cmd is registered and changes only in the cycle wrt is asserted.
  - No new wrt is issued while a transaction is outstanding.
- Boundary and error handling:
  - done received when no transaction is outstanding: ignored.
  - INT asserted during READ, CFG states, or PWR_WAIT: ignored. It is sampled again only in WAIT_INT; a still-high INT_ff2 there starts a new read sequence.
  - rst_n asserted mid-transaction: returns to PWR_WAIT and reruns configuration. The bench must also reset the SPI monarch.

## Timing
- Reset values: wrt=0, cmd=16'h0000, cfg_done=0, vld=0, and all data outputs = 16'h0000. The state is PWR_WAIT, the wait counter is 0, and the synchronizer flops are 0.
- First wrt occurs 2^INIT_WAIT_BITS + 1 rising edges after rst_n deasserts.
- Next wrt occurs exactly 1 cycle after the done of the previous transaction.
- cfg_done rises 1 cycle after the done of the 16'h1160 write.
- INT rise to first read wrt: 3 cycles (2 for synchronization, 1 for WAIT_INT to READ).
- vld pulses 1 cycle after the final read done. Data outputs update in the same edge that raises vld and hold until the next vld.

## Configuration
- INERT_ACCEL_EN defined:
  - The read list is extended with A800, A900 (ax low/high) and AA00, AB00 (ay low/high), issued after the yaw reads and in that order. That is 10 reads per interrupt.
  - ax and ay update with vld.
- INERT_ACCEL_EN undefined:
  - The read list is 6 reads.
  - ax and ay are constant 16'h0000.
  - The accelerator staging registers are not built.

## Test plan
- Reset and power-on: use INIT_WAIT_BITS=4 and a done model that responds 10 cycles after wrt. Check that no wrt occurs for 16 cycles, then cmd=0D02, then 1160, then cfg_done=1. Check that every output read 0 before that point.
- Single interrupt: use sensor bytes pitch=1234, roll=ABCD, yaw=8001. Raise INT, and drop it after the A200 done. Expect 6 wrt in order A200 through A700, then one vld with ptch_rt=16'h1234, roll_rt=16'hABCD, yaw_rt=16'h8001.
- Stray handshake: pulse done in WAIT_INT, and pulse INT during PWR_WAIT. Expect no wrt, no state change, and outputs unchanged.
- Back-to-back interrupts: hold INT high across a whole sequence. Expect a second read sequence to start 2 cycles after the first vld, with no sample torn between sequences.
- Reset mid-read: assert rst_n low after the A400 done. Expect every output back to 0, cfg_done=0, and configuration rerun after the wait.
- With INERT_ACCEL_EN defined: use ax bytes 00/7F and ay bytes FF/80. Expect 10 reads ending with AB00, ax=16'h7F00, ay=16'h80FF. Without the macro, expect ax=ay=0 throughout.

Source files
------------

// File: rtl/inert_seq.sv
// iNEMO sensor sequencer: power-on wait, two config writes, then rate reads per INT.
// Optional INERT_ACCEL_EN extends each read burst with the ax/ay accelerometer bytes.
module inert_seq #(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        cfg_done,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic [15:0] ax,
  output logic [15:0] ay
);

`ifdef INERT_ACCEL_EN
  localparam int NRD = 10;
`else
  localparam int NRD = 6;
`endif
  localparam logic [3:0] LAST = 4'(NRD - 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG_WR1,
    CFG_WR2,
    WAIT_INT,
    READ,
    UPDATE
  } state_t;

  state_t                    state;
  logic [INIT_WAIT_BITS-1:0] wcnt;
  logic                      INT_ff1;
  logic                      INT_ff2;
  logic                      pend;
  logic [3:0]                idx;
  logic [7:0]                stage [NRD];
  logic [7:0]                nb    [NRD];
  logic                      unused_hi;

  assign unused_hi = ^rd_data[15:8];

  function automatic logic [15:0] rd_cmd(
    input logic [3:0] i
  );
    rd_cmd = {1'b1, 7'h22 + {3'b000, i}, 8'h00};
  endfunction

  // final byte comes straight off the bus so vld follows the last done by one cycle
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      nb[i] = stage[i];
    end
    nb[NRD-1] = rd_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      INT_ff1 <= 1'b0;
      INT_ff2 <= 1'b0;
    end else begin
      INT_ff1 <= INT;
      INT_ff2 <= INT_ff1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWR_WAIT;
      wcnt     <= '0;
      pend     <= 1'b0;
      idx      <= '0;
      wrt      <= 1'b0;
      cmd      <= '0;
      cfg_done <= 1'b0;
      vld      <= 1'b0;
      ptch_rt  <= '0;
      roll_rt  <= '0;
      yaw_rt   <= '0;
`ifdef INERT_ACCEL_EN
      ax       <= '0;
      ay       <= '0;
`endif
      for (int i = 0; i < NRD; i++) begin
        stage[i] <= '0;
      end
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      unique case (state)
        PWR_WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (&wcnt) begin
            state <= CFG_WR1;
          end
        end
        CFG_WR1: begin
          if (!pend) begin
            wrt  <= 1'b1;
            cmd  <= 16'h0D02;
            pend <= 1'b1;
          end else if (done) begin
            wrt   <= 1'b1;
            cmd   <= 16'h1160;
            state <= CFG_WR2;
          end
        end
        CFG_WR2: begin
          if (done) begin
            pend     <= 1'b0;
            cfg_done <= 1'b1;
            state    <= WAIT_INT;
          end
        end
        WAIT_INT: begin
          if (INT_ff2) begin
            wrt   <= 1'b1;
            cmd   <= rd_cmd(4'd0);
            idx   <= 4'd0;
            pend  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (done) begin
            for (int i = 0; i < NRD; i++) begin
              if (idx == 4'(i)) begin
                stage[i] <= rd_data[7:0];
              end
            end
            if (idx == LAST) begin
              pend    <= 1'b0;
              vld     <= 1'b1;
              ptch_rt <= {nb[1], nb[0]};
              roll_rt <= {nb[3], nb[2]};
              yaw_rt  <= {nb[5], nb[4]};
`ifdef INERT_ACCEL_EN
              ax      <= {nb[7], nb[6]};
              ay      <= {nb[9], nb[8]};
`endif
              state   <= UPDATE;
            end else begin
              idx <= idx + 4'd1;
              wrt <= 1'b1;
              cmd <= rd_cmd(idx + 4'd1);
            end
          end
        end
        UPDATE: begin
          state <= WAIT_INT;
        end
        default: begin
          state <= PWR_WAIT;
        end
      endcase
    end
  end

`ifndef INERT_ACCEL_EN
  assign ax = '0;
  assign ay = '0;
`endif

endmodule

// File: tb/tb_inert_seq.sv
// Scoreboard bench for inert_seq: cmd and sample queues checked by a monitor.
// Covers power-on, stray handshakes, single/back-to-back INT and reset mid-read.
module tb_inert_seq;

`ifdef INERT_ACCEL_EN
  localparam int NRD = 10;
`else
  localparam int NRD = 6;
`endif

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] r;
    logic [15:0] y;
    logic [15:0] x;
    logic [15:0] z;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        spi_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        spi_rst = 1'b1;
  logic        done;
  logic [15:0] rd_data = '0;
  logic        wrt;
  logic [15:0] cmd;
  logic        cfg_done;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] roll_rt;
  logic [15:0] yaw_rt;
  logic [15:0] ax;
  logic [15:0] ay;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -10;
  int vld_cyc = -10;
  int wrt_cnt = 0;
  int vld_cnt = 0;
  int spi_cnt = 0;
  logic [15:0] spi_cmd = '0;
  logic [7:0]  sens [16];
  logic [15:0] exp_cmd [$];
  smp_t        exp_smp [$];
  logic [15:0] rlist [10] = '{
    16'hA200, 16'hA300, 16'hA400, 16'hA500, 16'hA600,
    16'hA700, 16'hA800, 16'hA900, 16'hAA00, 16'hAB00
  };

  assign done = spi_done | stray_done;

  inert_seq #(.INIT_WAIT_BITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (INT),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .cmd      (cmd),
    .cfg_done (cfg_done),
    .vld      (vld),
    .ptch_rt  (ptch_rt),
    .roll_rt  (roll_rt),
    .yaw_rt   (yaw_rt),
    .ax       (ax),
    .ay       (ay)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SPI monarch model: answers 10 cycles after wrt
  always @(negedge clk) begin
    if (spi_rst) begin
      spi_cnt  = 0;
      spi_done = 1'b0;
    end else begin
      spi_done = 1'b0;
      if (spi_cnt != 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          spi_done = 1'b1;
          rd_data  = {8'h5A, sens[spi_cmd[11:8]]};
          done_cyc = cyc;
        end
      end
      if (wrt) begin
        spi_cnt = 10;
        spi_cmd = cmd;
      end
    end
  end

  always @(negedge clk) begin
    smp_t s;
    if (wrt) begin
      wrt_cnt++;
      if (exp_cmd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wrt actual=%h required=none", cmd);
      end else begin
        chk("cmd", 32'(cmd), 32'(exp_cmd.pop_front()));
      end
    end
    if (vld) begin
      vld_cnt++;
      if (exp_smp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_vld actual=%h required=none", ptch_rt);
      end else begin
        s = exp_smp.pop_front();
        chk("ptch_rt", 32'(ptch_rt), 32'(s.p));
        chk("roll_rt", 32'(roll_rt), 32'(s.r));
        chk("yaw_rt", 32'(yaw_rt), 32'(s.y));
        chk("ax", 32'(ax), 32'(s.x));
        chk("ay", 32'(ay), 32'(s.z));
        chk("vld_latency", 32'(cyc), 32'(done_cyc + 1));
      end
      vld_cyc = cyc;
    end
  end

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      exp_cmd.push_back(rlist[i]);
    end
  endtask

  task automatic push_smp(input logic [15:0] p, input logic [15:0] r,
                          input logic [15:0] y, input logic [15:0] x,
                          input logic [15:0] z);
    smp_t s;
    s.p = p;
    s.r = r;
    s.y = y;
`ifdef INERT_ACCEL_EN
    s.x = x;
    s.z = z;
`else
    s.x = 16'h0000;
    s.z = 16'h0000;
`endif
    exp_smp.push_back(s);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wrt"}, 32'(wrt), 0);
    chk({tag, "_cmd"}, 32'(cmd), 0);
    chk({tag, "_cfg_done"}, 32'(cfg_done), 0);
    chk({tag, "_vld"}, 32'(vld), 0);
    chk({tag, "_ptch"}, 32'(ptch_rt), 0);
    chk({tag, "_roll"}, 32'(roll_rt), 0);
    chk({tag, "_yaw"}, 32'(yaw_rt), 0);
    chk({tag, "_ax"}, 32'(ax), 0);
    chk({tag, "_ay"}, 32'(ay), 0);
  endtask

  task automatic wait_wrt(output int n, input int budget);
    int s;
    s = wrt_cnt;
    n = 0;
    while (wrt_cnt == s && n < budget) begin
      tick();
      n++;
    end
    if (wrt_cnt == s) begin
      checks++;
      failures++;
      $display("FAIL wrt_timeout actual=%0d required=<%0d", n, budget);
    end
  endtask

  task automatic wait_vld(input int budget);
    int s;
    int n;
    s = vld_cnt;
    n = 0;
    while (vld_cnt == s && n < budget) begin
      tick();
      n++;
    end
    if (vld_cnt == s) begin
      checks++;
      failures++;
      $display("FAIL vld_timeout actual=%0d required=<%0d", n, budget);
    end
  endtask

  // releases reset, pulses INT during the wait, checks config sequence
  task automatic power_up(input string tag);
    int n;
    int s;
    n = 0;
    s = wrt_cnt;
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1160);
    spi_rst = 1'b0;
    rst_n   = 1'b1;
    while (wrt_cnt == s && n < 100) begin
      tick();
      n++;
      if (n == 3) INT = 1'b1;
      if (n == 6) INT = 1'b0;
      if (n == 16) begin
        chk({tag, "_pre_cfg_ptch"}, 32'(ptch_rt), 0);
        chk({tag, "_pre_cfg_done"}, 32'(cfg_done), 0);
        chk({tag, "_pre_cfg_wrt"}, 32'(wrt), 0);
      end
    end
    chk({tag, "_first_wrt_edges"}, 32'(n), 17);
    n = 0;
    while (!cfg_done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_cfg_done"}, 32'(cfg_done), 1);
    chk({tag, "_cfg_done_lat"}, 32'(cyc), 32'(done_cyc + 1));
    chk({tag, "_cfg_cmds_left"}, 32'(exp_cmd.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    for (int i = 0; i < 16; i++) sens[i] = 8'h00;
    sens[2]  = 8'h34; sens[3]  = 8'h12;
    sens[4]  = 8'hCD; sens[5]  = 8'hAB;
    sens[6]  = 8'h01; sens[7]  = 8'h80;
    sens[8]  = 8'h00; sens[9]  = 8'h7F;
    sens[10] = 8'hFF; sens[11] = 8'h80;

    repeat (3) tick();
    check_zero("reset");
    power_up("pwr");

    s = wrt_cnt;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (20) tick();
    chk("stray_no_wrt", 32'(wrt_cnt), 32'(s));
    chk("stray_ptch", 32'(ptch_rt), 0);
    chk("stray_cfg_done", 32'(cfg_done), 1);

    push_seq(NRD);
    push_smp(16'h1234, 16'hABCD, 16'h8001, 16'h7F00, 16'h80FF);
    INT = 1'b1;
    wait_wrt(n, 20);
    chk("int_to_wrt", 32'(n), 3);
    repeat (12) tick();
    INT = 1'b0;
    wait_vld(300);
    repeat (5) tick();
    chk("hold_ptch", 32'(ptch_rt), 32'h1234);
    chk("hold_yaw", 32'(yaw_rt), 32'h8001);
    chk("single_queue_empty", 32'(exp_cmd.size()), 0);

    push_seq(NRD);
    push_seq(NRD);
    push_smp(16'h1234, 16'hABCD, 16'h8001, 16'h7F00, 16'h80FF);
    push_smp(16'h5678, 16'h0F0F, 16'h7FFE, 16'h2211, 16'h4433);
    INT = 1'b1;
    wait_vld(300);
    sens[2]  = 8'h78; sens[3]  = 8'h56;
    sens[4]  = 8'h0F; sens[5]  = 8'h0F;
    sens[6]  = 8'hFE; sens[7]  = 8'h7F;
    sens[8]  = 8'h11; sens[9]  = 8'h22;
    sens[10] = 8'h33; sens[11] = 8'h44;
    wait_wrt(n, 20);
    chk("b2b_gap", 32'(cyc), 32'(vld_cyc + 2));
    repeat (12) tick();
    INT = 1'b0;
    wait_vld(300);
    repeat (30) tick();
    chk("b2b_queue_empty", 32'(exp_cmd.size()), 0);
    chk("b2b_hold_roll", 32'(roll_rt), 32'h0F0F);

    push_seq(4);
    s = wrt_cnt;
    INT = 1'b1;
    n = 0;
    while (wrt_cnt < s + 4 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_read_reached", 32'(wrt_cnt), 32'(s + 4));
    INT = 1'b0;
    rst_n = 1'b0;
    spi_rst = 1'b1;
    tick();
    check_zero("mid_rst");
    chk("mid_rst_queue", 32'(exp_cmd.size()), 0);
    repeat (3) tick();
    power_up("rerun");
    chk("rerun_ptch", 32'(ptch_rt), 0);
    chk("rerun_vld_queue", 32'(exp_smp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
